des_key_schedule: RTL and testbench

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

---
 rtl/des_pkg.sv | 55 +++++
 rtl/des_pc2.sv | 21 ++
 rtl/des_key_schedule.sv | 171 +++++++++++++++++
 tb/tb_des_key_schedule.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared constants for the DES key schedule:
//   - PC1_TABLE      : 56-entry Permuted Choice 1 (FIPS 46-3 bit numbers, 1 = MSB)
//   - PC2_TABLE      : 48-entry Permuted Choice 2 (1-based positions in C||D)
//   - SHIFT_SCHEDULE : per-round left-rotation amounts, entry 0 = round 1
//   - ks_state_t     : key schedule FSM state encoding
//   - rotl28/rotr28  : 28-bit rotations by 1 or 2
// -----------------------------------------------------------------------------
package des_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ks_state_t;

    // Output bit i (0 = FIPS bit 1) of PC-1 takes key bit PC1_TABLE[i].
    localparam int unsigned PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Output bit i (0 = round key bit 1) of PC-2 takes C||D bit PC2_TABLE[i].
    localparam int unsigned PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_SCHEDULE [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Rotation amounts are only ever 1 or 2.
    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// -----------------------------------------------------------------------------
// des_pc2
// Combinational Permuted Choice 2.
// Ports:
//   cd  [55:0] in  : C||D, bit 55 = C bit 1
//   key [47:0] out : round key, bit 47 = PC-2 output bit 1
// -----------------------------------------------------------------------------
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] key
);

    generate
        for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
            assign key[47 - gi] = cd[56 - PC2_TABLE[gi]];
        end
    endgenerate

endmodule

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
// Issues the 16 DES round keys one per handshake, in encrypt order (K1..K16)
// or decrypt order (K16..K1). C,D are rotated in place after each accepted key
// so only one 56-bit state register is needed.
//
// Ports:
//   clk        in      sole clock
//   rst        in      synchronous active-high reset
//   key_in     in [64] DES key, bit 63 = FIPS bit 1, sampled on accepted start
//   decrypt    in      key order select, sampled with key_in
//   start      in      request a new schedule (accepted only in IDLE)
//   key_ready  in      downstream accepts key_out this cycle
//   key_valid  out     key_out holds a valid round key
//   key_out    out[48] round key, bit 47 = PC-2 output bit 1
//   round_idx  out [4] issue-order index of key_out
//   busy       out     schedule in progress
//   done       out     one-cycle pulse after the 16th key is accepted
//   parity_err out     (only with DES_KEY_PARITY_CHECK_EN) some key byte had
//                      even parity at the last accepted start
//
// Optional feature macro: DES_KEY_PARITY_CHECK_EN
// -----------------------------------------------------------------------------
module des_key_schedule
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        start,
    input  logic        key_ready,
    output logic        key_valid,
    output logic [47:0] key_out,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    output logic        parity_err
`endif
);

    ks_state_t   state_reg, state_next;
    logic [27:0] c_reg, c_next;
    logic [27:0] d_reg, d_next;
    logic [3:0]  round_idx_reg;
    logic        decrypt_reg;
    logic        done_reg;

    logic [55:0] pc1_bits;
    logic        handshake;
    logic        accept;
    logic        last_key;
    logic [3:0]  shift_sel;
    logic [1:0]  shift_amt;

    // PC-1: key_in bit 63 is FIPS bit 1.
    generate
        for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
            assign pc1_bits[55 - gi] = key_in[64 - PC1_TABLE[gi]];
        end
    endgenerate

    assign handshake = (state_reg == ST_RUN) && key_ready;
    // A start that coincides with the done pulse is dropped.
    assign accept    = (state_reg == ST_IDLE) && start && !done_reg;
    assign last_key  = handshake && (round_idx_reg == 4'd15);

    // Register holds C(r+1) in encrypt order, so the next rotation is the
    // one for round r+2 (0-based entry r+1). In decrypt order it holds
    // C(16-r) and stepping back undoes round 16-r's rotation (entry 15-r).
    // Entry wraps to 0 on the final key; the result is discarded then.
    always_comb begin
        shift_sel = decrypt_reg ? (4'd15 - round_idx_reg) : (round_idx_reg + 4'd1);
        shift_amt = SHIFT_SCHEDULE[shift_sel];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)   state_next = ST_RUN;
            ST_RUN:  if (last_key) state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        c_next = c_reg;
        d_next = d_reg;
        if (accept) begin
            // Decrypt starts at C16,D16 which equal C0,D0 (total rotation 28).
            if (decrypt) begin
                c_next = pc1_bits[55:28];
                d_next = pc1_bits[27:0];
            end else begin
                c_next = rotl28(pc1_bits[55:28], 2'd1);
                d_next = rotl28(pc1_bits[27:0], 2'd1);
            end
        end else if (handshake) begin
            if (decrypt_reg) begin
                c_next = rotr28(c_reg, shift_amt);
                d_next = rotr28(d_reg, shift_amt);
            end else begin
                c_next = rotl28(c_reg, shift_amt);
                d_next = rotl28(d_reg, shift_amt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            c_reg         <= '0;
            d_reg         <= '0;
            round_idx_reg <= '0;
            decrypt_reg   <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            c_reg     <= c_next;
            d_reg     <= d_next;
            done_reg  <= last_key;
            if (accept) begin
                round_idx_reg <= '0;
                decrypt_reg   <= decrypt;
            end else if (handshake) begin
                // 15 + 1 wraps to 0, so IDLE reads 0 after the last key.
                round_idx_reg <= round_idx_reg + 4'd1;
            end
        end
    end

    des_pc2 u_pc2 (
        .cd  ({c_reg, d_reg}),
        .key (key_out)
    );

    assign key_valid = (state_reg == ST_RUN);
    assign busy      = (state_reg == ST_RUN);
    assign round_idx = round_idx_reg;
    assign done      = done_reg;

`ifdef DES_KEY_PARITY_CHECK_EN
    // Each DES key byte must have odd parity.
    logic [7:0] byte_even;
    logic       parity_err_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_parity
            assign byte_even[gi] = ~^key_in[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_reg <= 1'b0;
        end else if (accept) begin
            parity_err_reg <= |byte_even;
        end
    end

    assign parity_err = parity_err_reg;
`else
    // Parity bits (FIPS bits 8,16,...,64) are deliberately ignored.
    logic unused_parity_bits;
    assign unused_parity_bits = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                                  key_in[24], key_in[16], key_in[8],  key_in[0]};
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_des_key_schedule
// Randomized self-checking bench for des_key_schedule. Round keys are
// predicted from the DES tables with cumulative rotation amounts.
// Honors DES_KEY_PARITY_CHECK_EN when defined for the build.
// -----------------------------------------------------------------------------
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key_in;
    logic        decrypt;
    logic        start;
    logic        key_ready;
    logic        key_valid;
    logic [47:0] key_out;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;
`ifdef DES_KEY_PARITY_CHECK_EN
    logic        parity_err;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    des_key_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .decrypt   (decrypt),
        .start     (start),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .key_out   (key_out),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
`ifdef DES_KEY_PARITY_CHECK_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Round key K<round> (1..16): C0,D0 rotated left by the sum of the
    // first <round> shift amounts, then PC-2.
    function automatic logic [47:0] model_key(input logic [63:0] key, input int round);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] k;
        int total;
        total = 0;
        for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 0; i < round; i++) total += SHIFTS[i];
        for (int i = 0; i < total; i++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int j = 0; j < 48; j++) k[47 - j] = cd[56 - PC2_T[j]];
        return k;
    endfunction

    function automatic logic model_parity_err(input logic [63:0] key);
        logic err;
        err = 1'b0;
        for (int b = 0; b < 8; b++) begin
            int ones;
            ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(key[b*8 + i]);
            if (ones % 2 == 0) err = 1'b1;
        end
        return err;
    endfunction

    // One full schedule with handshake checking; got_keys returns the
    // accepted keys in issue order.
    task automatic run_sched(input logic [63:0] key, input bit dec, input int ready_pct,
                             input bit inject_start, input bit start_on_done,
                             output logic [47:0] got_keys [16]);
        logic [47:0] exp_keys [16];
        logic [47:0] prev_key;
        logic [3:0]  prev_idx;
        bit          stalled;
        bit          go;
        int          hs;
        int          cycles;
        for (int r = 0; r < 16; r++) begin
            exp_keys[r] = dec ? model_key(key, 16 - r) : model_key(key, r + 1);
            got_keys[r] = '0;
        end
        @(negedge clk);
        start     = 1'b1;
        key_in    = key;
        decrypt   = dec;
        key_ready = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        key_in  = {$urandom, $urandom};
        decrypt = ~dec;
        cycles  = 1;
        check_val("first_valid", 64'(key_valid), 64'd1);
`ifdef DES_KEY_PARITY_CHECK_EN
        check_val("parity_err", 64'(parity_err), 64'(model_parity_err(key)));
`endif
        hs = 0;
        stalled = 1'b0;
        prev_key = '0;
        prev_idx = '0;
        while (hs < 16 && cycles < 400) begin
            check_val("busy_run", 64'(busy), 64'd1);
            if (stalled) begin
                check_val("stall_key", 64'(key_out), 64'(prev_key));
                check_val("stall_idx", 64'(round_idx), 64'(prev_idx));
            end
            go = ($urandom_range(99) < ready_pct);
            key_ready = go;
            if (go) begin
                check_val("round_idx", 64'(round_idx), 64'(hs));
                check_val("key_out", 64'(key_out), 64'(exp_keys[hs]));
                got_keys[hs] = key_out;
                hs++;
            end
            stalled  = !go;
            prev_key = key_out;
            prev_idx = round_idx;
            start = inject_start && (hs == 5);
            @(negedge clk);
            cycles++;
        end
        key_ready = 1'b0;
        start     = 1'b0;
        check_val("handshakes", 64'(hs), 64'd16);
        check_val("done_pulse", 64'(done), 64'd1);
        check_val("busy_at_done", 64'(busy), 64'd0);
        if (ready_pct >= 100) check_val("done_latency", 64'(cycles), 64'd17);
        if (start_on_done) begin
            start  = 1'b1;
            key_in = {$urandom, $urandom};
        end
        @(negedge clk);
        start = 1'b0;
        check_val("done_one_cycle", 64'(done), 64'd0);
        check_val("idle_after_done", 64'(busy), 64'd0);
        $display("[TB] schedule key=%h dec=%0d ready%%=%0d inject=%0d cycles=%0d hs=%0d",
                 key, dec, ready_pct, inject_start, cycles, hs);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_valid"}, 64'(key_valid), 64'd0);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_done"}, 64'(done), 64'd0);
        check_val({tag, "_key"}, 64'(key_out), 64'd0);
        check_val({tag, "_idx"}, 64'(round_idx), 64'd0);
`ifdef DES_KEY_PARITY_CHECK_EN
        check_val({tag, "_perr"}, 64'(parity_err), 64'd0);
`endif
    endtask

    localparam logic [63:0] VEC_KEY = 64'h133457799BBCDFF1;

    initial begin
        logic [47:0] enc_keys [16];
        logic [47:0] dec_keys [16];
        logic [47:0] tmp_keys [16];
        int waited;

        rst = 1'b1; key_in = '0; decrypt = 1'b0; start = 1'b0; key_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");
        $display("[TB] reset state checked");

        // Reference vector, encrypt and decrypt order.
        run_sched(VEC_KEY, 1'b0, 100, 1'b0, 1'b0, enc_keys);
        check_val("vec_k1", 64'(enc_keys[0]), 64'h1B02EFFC7072);
        check_val("vec_k16", 64'(enc_keys[15]), 64'hCB3D8B0E17F5);
        run_sched(VEC_KEY, 1'b1, 100, 1'b0, 1'b0, dec_keys);
        check_val("vec_dec0", 64'(dec_keys[0]), 64'hCB3D8B0E17F5);
        check_val("vec_dec15", 64'(dec_keys[15]), 64'h1B02EFFC7072);
        for (int r = 0; r < 16; r++)
            check_val("dec_reverse", 64'(dec_keys[r]), 64'(enc_keys[15 - r]));

        // Random backpressure on the reference key.
        run_sched(VEC_KEY, 1'b0, 45, 1'b0, 1'b0, tmp_keys);
        for (int r = 0; r < 16; r++)
            check_val("stall_seq", 64'(tmp_keys[r]), 64'(enc_keys[r]));

        // Start during RUN with a different key, and start on the done cycle.
        run_sched(VEC_KEY, 1'b0, 70, 1'b1, 1'b1, tmp_keys);
        run_sched(VEC_KEY, 1'b1, 100, 1'b1, 1'b0, tmp_keys);

        // Random keys and orders.
        for (int t = 0; t < 8; t++)
            run_sched({$urandom, $urandom}, 1'($urandom_range(1)), 40 + 10 * t,
                      1'($urandom_range(1)), 1'($urandom_range(1)), tmp_keys);

        // Reset at round_idx 7, asserted together with start and a handshake.
        @(negedge clk);
        start = 1'b1; key_in = VEC_KEY; decrypt = 1'b0;
        @(negedge clk);
        start = 1'b0; key_ready = 1'b1;
        waited = 0;
        while (round_idx != 4'd7 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check_val("reach_idx7", 64'(round_idx), 64'd7);
        rst = 1'b1; start = 1'b1; key_in = 64'h0E329232EA6D0D73;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; key_ready = 1'b0;
        check_outputs_zero("midrun_rst");
        @(negedge clk);
        check_val("rst_no_done", 64'(done), 64'd0);
        check_val("rst_idle", 64'(busy), 64'd0);
        $display("[TB] mid-run reset at round_idx 7 checked");
        run_sched(VEC_KEY, 1'b0, 100, 1'b0, 1'b0, tmp_keys);
        check_val("post_rst_k1", 64'(tmp_keys[0]), 64'h1B02EFFC7072);

`ifdef DES_KEY_PARITY_CHECK_EN
        // Bad parity key still produces its schedule.
        run_sched(64'h123457799BBCDFF1, 1'b0, 80, 1'b0, 1'b0, tmp_keys);
        check_val("bad_parity_flag", 64'(parity_err), 64'd1);
        run_sched(VEC_KEY, 1'b0, 100, 1'b0, 1'b0, tmp_keys);
        check_val("good_parity_flag", 64'(parity_err), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
